// File: rtl/control_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
package control_fsm_pkg;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJump, ClsIllegal
  } inst_cls_e;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluSll   = 4'b0010,
    AluSlt   = 4'b0011,
    AluSltu  = 4'b0100,
    AluXor   = 4'b0101,
    AluSrl   = 4'b0110,
    AluSra   = 4'b0111,
    AluOr    = 4'b1000,
    AluAnd   = 4'b1001,
    AluPassB = 4'b1010
  } alu_op_e;

  localparam logic [2:0] ImmNone = 3'b000;
  localparam logic [2:0] ImmI    = 3'b001;
  localparam logic [2:0] ImmS    = 3'b010;
  localparam logic [2:0] ImmB    = 3'b011;
  localparam logic [2:0] ImmU    = 3'b100;
  localparam logic [2:0] ImmJ    = 3'b101;

  localparam logic [1:0] WbMem = 2'b00;
  localparam logic [1:0] WbAlu = 2'b01;
  localparam logic [1:0] WbPc  = 2'b10;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  // alt selects SUB (funct3 000) or SRA (funct3 101)
  function automatic alu_op_e alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    unique case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational decode of the instruction register into static datapath selects.
module inst_decoder
  import control_fsm_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  imm_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic [3:0]  alu_sel,
  output logic        br_un,
  output inst_cls_e   cls,
  output logic        legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  always_comb begin
    imm_sel = ImmNone;
    a_sel   = 1'b0;
    b_sel   = 1'b1;
    alu_sel = AluAdd;
    br_un   = 1'b0;
    cls     = ClsIllegal;
    legal   = 1'b1;
    case (opcode)
      OpcOp: begin
        cls     = ClsAlu;
        b_sel   = 1'b0;
        alu_sel = alu_op(funct3, ir[30]);
        legal   = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OpcOpImm: begin
        cls     = ClsAlu;
        imm_sel = ImmI;
        // Only shifts carry funct7; imm[10] distinguishes SRAI from SRLI
        if (funct3 == 3'b101) begin
          alu_sel = alu_op(funct3, ir[30]);
          legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          alu_sel = alu_op(funct3, 1'b0);
          legal   = (funct3 != 3'b001) || (funct7 == 7'b0000000);
        end
      end
      OpcLoad: begin
        cls     = ClsLoad;
        imm_sel = ImmI;
        legal   = (funct3 == 3'b010);
      end
      OpcStore: begin
        cls     = ClsStore;
        imm_sel = ImmS;
        legal   = (funct3 == 3'b010);
      end
      OpcBranch: begin
        cls     = ClsBranch;
        imm_sel = ImmB;
        a_sel   = 1'b1;
        br_un   = funct3[2] & funct3[1];
        legal   = (funct3[2:1] != 2'b01);
      end
      OpcJal: begin
        cls     = ClsJump;
        imm_sel = ImmJ;
        a_sel   = 1'b1;
      end
      OpcJalr: begin
        cls     = ClsJump;
        imm_sel = ImmI;
        legal   = (funct3 == 3'b000);
      end
      OpcLui: begin
        cls     = ClsAlu;
        imm_sel = ImmU;
        alu_sel = AluPassB;
      end
      OpcAuipc: begin
        cls     = ClsAlu;
        imm_sel = ImmU;
        a_sel   = 1'b1;
      end
      default: begin
        b_sel = 1'b0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing and control strobes.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        PCSel,
  output logic        PCWrite,
  output logic [2:0]  ImmSel,
  output logic        RegWEn,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [3:0]  ALUSel,
  output logic        MemEn,
  output logic        MemRW,
  output logic [1:0]  WBSel,
  output logic        illegal
);

  state_e      state_q;
  logic [31:0] ir_q;

  logic [2:0]  dec_imm_sel;
  logic        dec_a_sel;
  logic        dec_b_sel;
  logic [3:0]  dec_alu_sel;
  logic        dec_br_un;
  inst_cls_e   dec_cls;
  logic        dec_legal;
  logic        static_en;
  logic        br_taken;

  inst_decoder u_inst_decoder (
    .ir      (ir_q),
    .imm_sel (dec_imm_sel),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .alu_sel (dec_alu_sel),
    .br_un   (dec_br_un),
    .cls     (dec_cls),
    .legal   (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ir_q    <= NopInst;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) begin
            ir_q    <= inst;
            state_q <= StDecode;
          end
        end
        StDecode: state_q <= dec_legal ? StExec : StFetch;
        StExec: begin
          unique case (dec_cls)
            ClsLoad, ClsStore: state_q <= StMem;
            ClsBranch:         state_q <= StFetch;
            default:           state_q <= StWb;
          endcase
        end
        StMem: begin
          if (dmem_ready) state_q <= (dec_cls == ClsStore) ? StFetch : StWb;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    case (ir_q[14:12])
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = !BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = !BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  // Selects are blanked in FETCH (and so during reset) and for illegal words
  assign static_en = (state_q != StFetch) && dec_legal;
  assign ImmSel    = static_en ? dec_imm_sel : ImmNone;
  assign ASel      = static_en & dec_a_sel;
  assign BSel      = static_en & dec_b_sel;
  assign ALUSel    = static_en ? dec_alu_sel : 4'b0000;
  assign BrUn      = static_en & dec_br_un;

  always_comb begin
    PCSel   = 1'b0;
    PCWrite = 1'b0;
    RegWEn  = 1'b0;
    MemEn   = 1'b0;
    MemRW   = 1'b0;
    WBSel   = WbMem;
    illegal = 1'b0;
    case (state_q)
      StDecode: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          PCWrite = 1'b1;
        end
      end
      StExec: begin
        if (dec_cls == ClsBranch) begin
          PCWrite = 1'b1;
          PCSel   = br_taken;
        end
      end
      StMem: begin
        MemEn   = 1'b1;
        MemRW   = (dec_cls == ClsStore);
        PCWrite = dmem_ready && (dec_cls == ClsStore);
      end
      StWb: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        PCSel   = (dec_cls == ClsJump);
        if (dec_cls == ClsLoad)      WBSel = WbMem;
        else if (dec_cls == ClsJump) WBSel = WbPc;
        else                         WBSel = WbAlu;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle expected control vectors via a scoreboard queue.
module tb_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        imem_ready;
  logic        dmem_ready;
  logic        BrEq;
  logic        BrLT;
  logic        PCSel;
  logic        PCWrite;
  logic [2:0]  ImmSel;
  logic        RegWEn;
  logic        BrUn;
  logic        ASel;
  logic        BSel;
  logic [3:0]  ALUSel;
  logic        MemEn;
  logic        MemRW;
  logic [1:0]  WBSel;
  logic        illegal;

  logic [17:0] obs;
  logic [17:0] sb_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] SUB   = 32'h4020_81B3;
  localparam logic [31:0] SRAI  = 32'h4020_D093;
  localparam logic [31:0] LUI   = 32'h1234_50B7;
  localparam logic [31:0] AUIPC = 32'h0000_1097;
  localparam logic [31:0] JAL   = 32'h0080_00EF;
  localparam logic [31:0] JALR  = 32'h0000_80E7;
  localparam logic [31:0] LW    = 32'h0080_A283;
  localparam logic [31:0] SW    = 32'h0050_A623;
  localparam logic [31:0] BEQ   = 32'h0020_8863;
  localparam logic [31:0] BLTU  = 32'h0020_E863;
  localparam logic [31:0] BGE   = 32'h0020_D863;
  localparam logic [17:0] Z     = 18'h0;

  control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .BrEq       (BrEq),
    .BrLT       (BrLT),
    .PCSel      (PCSel),
    .PCWrite    (PCWrite),
    .ImmSel     (ImmSel),
    .RegWEn     (RegWEn),
    .BrUn       (BrUn),
    .ASel       (ASel),
    .BSel       (BSel),
    .ALUSel     (ALUSel),
    .MemEn      (MemEn),
    .MemRW      (MemRW),
    .WBSel      (WBSel),
    .illegal    (illegal)
  );

  assign obs = {PCSel, PCWrite, ImmSel, RegWEn, BrUn, ASel, BSel, ALUSel, MemEn, MemRW, WBSel,
                illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ov(input logic pcsel, input logic pcwrite,
                                     input logic [2:0] imm, input logic regwen,
                                     input logic brun, input logic asel, input logic bsel,
                                     input logic [3:0] alu, input logic memen,
                                     input logic memrw, input logic [1:0] wbsel,
                                     input logic ill);
    return {pcsel, pcwrite, imm, regwen, brun, asel, bsel, alu, memen, memrw, wbsel, ill};
  endfunction

  task automatic check();
    logic [17:0] e;
    string       t;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %05h required entry", obs);
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %05h expected %05h", t, obs, e);
    end
  endtask

  // Called at a falling edge: drive, record expectation, compare, advance one cycle
  task automatic step(input logic [31:0] i, input logic im, input logic dm, input logic beq,
                      input logic blt, input logic [17:0] exp, input string tag);
    inst       = i;
    imem_ready = im;
    dmem_ready = dm;
    BrEq       = beq;
    BrLT       = blt;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    #1 check();
    @(negedge clk);
  endtask

  task automatic run_alu(input logic [31:0] i, input logic [2:0] imm, input logic a,
                         input logic b, input logic [3:0] alu, input logic [1:0] wb,
                         input logic pcs, input string tag);
    logic [17:0] s;
    s = ov(0, 0, imm, 0, 0, a, b, alu, 0, 0, 2'b00, 0);
    step(i, 1, 0, 0, 0, Z, {tag, "_fetch"});
    step(i, 1, 0, 0, 0, s, {tag, "_decode"});
    step(i, 1, 0, 0, 0, s, {tag, "_exec"});
    step(i, 1, 0, 0, 0, ov(pcs, 1, imm, 1, 0, a, b, alu, 0, 0, wb, 0), {tag, "_wb"});
  endtask

  task automatic run_br(input logic [31:0] i, input logic brun, input logic beq,
                        input logic blt, input logic taken, input string tag);
    step(i, 1, 0, 0, 0, Z, {tag, "_fetch"});
    step(i, 1, 0, 0, 0, ov(0, 0, 3'b011, 0, brun, 1, 1, 4'h0, 0, 0, 2'b00, 0), {tag, "_decode"});
    step(i, 1, 0, beq, blt, ov(taken, 1, 3'b011, 0, brun, 1, 1, 4'h0, 0, 0, 2'b00, 0),
         {tag, "_exec"});
  endtask

  task automatic run_bad(input logic [31:0] i, input string tag);
    step(i, 1, 0, 0, 0, Z, {tag, "_fetch"});
    step(i, 1, 0, 0, 0, ov(0, 1, 3'b000, 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 1), {tag, "_decode"});
    step(i, 0, 0, 0, 0, Z, {tag, "_back_to_fetch"});
  endtask

  initial begin
    logic [17:0] ls;
    logic [17:0] ss;
    ls = ov(0, 0, 3'b001, 0, 0, 0, 1, 4'h0, 0, 0, 2'b00, 0);
    ss = ov(0, 0, 3'b010, 0, 0, 0, 1, 4'h0, 0, 0, 2'b00, 0);

    rst_n = 1'b0; inst = SW; imem_ready = 1'b1; dmem_ready = 1'b1; BrEq = 1'b0; BrLT = 1'b0;
    @(negedge clk);
    step(SW, 1, 1, 0, 0, Z, "reset_outputs_zero");
    step(SW, 1, 1, 1, 1, Z, "reset_hold");
    rst_n = 1'b1;
    step(ADD, 0, 0, 0, 0, Z, "fetch_wait0");
    step(ADD, 0, 0, 0, 0, Z, "fetch_wait1");

    run_alu(ADD,   3'b000, 0, 0, 4'b0000, 2'b01, 0, "add");
    run_alu(SUB,   3'b000, 0, 0, 4'b0001, 2'b01, 0, "sub");
    run_alu(SRAI,  3'b001, 0, 1, 4'b0111, 2'b01, 0, "srai");
    run_alu(LUI,   3'b100, 0, 1, 4'b1010, 2'b01, 0, "lui");
    run_alu(AUIPC, 3'b100, 1, 1, 4'b0000, 2'b01, 0, "auipc");
    run_alu(JAL,   3'b101, 1, 1, 4'b0000, 2'b10, 1, "jal");
    run_alu(JALR,  3'b001, 0, 1, 4'b0000, 2'b10, 1, "jalr");

    // lw with two data-memory wait cycles: 7 cycles in total
    step(LW, 1, 0, 0, 0, Z, "lw_fetch");
    step(LW, 1, 0, 0, 0, ls, "lw_decode");
    step(LW, 1, 0, 0, 0, ls, "lw_exec");
    step(LW, 1, 0, 0, 0, ov(0, 0, 3'b001, 0, 0, 0, 1, 4'h0, 1, 0, 2'b00, 0), "lw_mem_wait0");
    step(LW, 1, 0, 0, 0, ov(0, 0, 3'b001, 0, 0, 0, 1, 4'h0, 1, 0, 2'b00, 0), "lw_mem_wait1");
    step(LW, 1, 1, 0, 0, ov(0, 0, 3'b001, 0, 0, 0, 1, 4'h0, 1, 0, 2'b00, 0), "lw_mem_done");
    step(LW, 1, 0, 0, 0, ov(0, 1, 3'b001, 1, 0, 0, 1, 4'h0, 0, 0, 2'b00, 0), "lw_wb");

    step(SW, 1, 0, 0, 0, Z, "sw_fetch");
    step(SW, 1, 0, 0, 0, ss, "sw_decode");
    step(SW, 1, 0, 0, 0, ss, "sw_exec");
    step(SW, 1, 0, 0, 0, ov(0, 0, 3'b010, 0, 0, 0, 1, 4'h0, 1, 1, 2'b00, 0), "sw_mem_wait");
    step(SW, 1, 1, 0, 0, ov(0, 1, 3'b010, 0, 0, 0, 1, 4'h0, 1, 1, 2'b00, 0), "sw_mem_done");

    run_br(BEQ,  0, 1, 0, 1, "beq_taken");
    run_br(BEQ,  0, 0, 0, 0, "beq_not_taken");
    run_br(BLTU, 1, 0, 1, 1, "bltu_taken");
    run_br(BLTU, 1, 0, 0, 0, "bltu_not_taken");
    run_br(BGE,  0, 0, 0, 1, "bge_taken");

    run_bad(32'hFFFF_FFFF, "illegal_ones");
    run_bad(32'h0020_A863, "illegal_br010");
    run_bad(32'h0080_8283, "illegal_lb");

    // Reset asserted in the middle of a store's MEM cycle
    step(SW, 1, 0, 0, 0, Z, "rst_sw_fetch");
    step(SW, 1, 0, 0, 0, ss, "rst_sw_decode");
    step(SW, 1, 0, 0, 0, ss, "rst_sw_exec");
    dmem_ready = 1'b0;
    sb_q.push_back(ov(0, 0, 3'b010, 0, 0, 0, 1, 4'h0, 1, 1, 2'b00, 0));
    tag_q.push_back("rst_sw_mem");
    #1 check();
    #2 rst_n = 1'b0;
    sb_q.push_back(Z);
    tag_q.push_back("rst_mid_mem_zero");
    #1 check();
    @(negedge clk);
    step(SW, 1, 1, 0, 0, Z, "rst_mid_mem_hold");
    rst_n = 1'b1;
    step(ADD, 0, 0, 0, 0, Z, "post_rst_idle");
    run_alu(ADD, 3'b000, 0, 0, 4'b0000, 2'b01, 0, "post_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
